// File: rtl/sim_ctrl_host.sv
// Bus initiator for the simulator-control block: buffers a byte stream into CHAR_OUT
// writes, then issues a single halt write to SIM_CTRL once all bytes have drained.
module sim_ctrl_host #(
  parameter logic [31:0] BaseAddr   = 32'h0002_0000,
  parameter int unsigned FifoDepth  = 8,
  parameter int unsigned RspTimeout = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         char_valid_i,
  input  logic [7:0]                   char_i,
  output logic                         char_ready_o,
  input  logic                         halt_i,
  output logic                         req_o,
  output logic                         we_o,
  output logic [3:0]                   be_o,
  output logic [31:0]                  addr_o,
  output logic [31:0]                  wdata_o,
  input  logic                         rvalid_i,
  output logic [$clog2(FifoDepth):0]   count_o,
  output logic                         busy_o,
  output logic                         halted_o,
  output logic                         err_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TmrW = $clog2(RspTimeout + 1);

  localparam logic [31:0] CharOutAddr = BaseAddr + 32'h0;
  localparam logic [31:0] SimCtrlAddr = BaseAddr + 32'h8;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StHalted
  } state_e;

  state_e r_state;
  state_e w_state_d;

  logic [7:0]      r_mem [FifoDepth];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;

  logic            r_halt_pend;
  logic            r_halted;
  logic            r_err;
  logic            r_is_halt;
  logic [TmrW-1:0] r_wait_cnt;

  logic            r_req;
  logic            r_we;
  logic [3:0]      r_be;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_start_halt;
  logic w_finish;
  logic w_timeout;

  assign w_full  = (r_count == CntW'(FifoDepth));
  assign w_empty = (r_count == '0);

  // Ready depends on registered state only, so the producer sees no input-to-output path.
  assign char_ready_o = !w_full && !r_halt_pend && !r_halted;
  assign w_push       = char_valid_i && char_ready_o;

  always_comb begin
    w_state_d    = r_state;
    w_pop        = 1'b0;
    w_start_halt = 1'b0;
    w_finish     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_state_d = StIssue;
        end else if (r_halt_pend) begin
          w_start_halt = 1'b1;
          w_state_d    = StIssue;
        end
      end
      StIssue: begin
        w_state_d = StWait;
      end
      StWait: begin
        if (rvalid_i) begin
          w_finish = 1'b1;
        end else if (r_wait_cnt == TmrW'(RspTimeout - 1)) begin
          w_finish  = 1'b1;
          w_timeout = 1'b1;
        end
        // A lost halt response still ends the run; there is nothing left to retry.
        if (w_finish) begin
          w_state_d = r_is_halt ? StHalted : StIdle;
        end
      end
      StHalted: begin
        w_state_d = StHalted;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read when the occupancy says they are valid.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= char_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_halt_pend <= 1'b0;
      r_halted    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_finish && r_is_halt) begin
        r_halt_pend <= 1'b0;
        r_halted    <= 1'b1;
      end else if (halt_i && !r_halt_pend && !r_halted) begin
        r_halt_pend <= 1'b1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wait_cnt <= '0;
    end else if (r_state == StIssue) begin
      r_wait_cnt <= '0;
    end else if (r_state == StWait) begin
      r_wait_cnt <= r_wait_cnt + TmrW'(1);
    end
  end

  // Bus outputs are loaded on entry to ISSUE; be/addr/wdata then hold until the next one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_be      <= 4'b0000;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_is_halt <= 1'b0;
    end else begin
      r_req <= w_pop || w_start_halt;
      r_we  <= w_pop || w_start_halt;
      if (w_pop) begin
        r_be      <= 4'b0001;
        r_addr    <= CharOutAddr;
        r_wdata   <= {24'h0, r_mem[r_rptr]};
        r_is_halt <= 1'b0;
      end else if (w_start_halt) begin
        r_be      <= 4'b0001;
        r_addr    <= SimCtrlAddr;
        r_wdata   <= 32'h1;
        r_is_halt <= 1'b1;
      end
    end
  end

  assign req_o    = r_req;
  assign we_o     = r_we;
  assign be_o     = r_be;
  assign addr_o   = r_addr;
  assign wdata_o  = r_wdata;
  assign count_o  = r_count;
  assign busy_o   = (r_state != StIdle) || !w_empty || r_halt_pend;
  assign halted_o = r_halted;
  assign err_o    = r_err;

endmodule

// File: tb/tb_sim_ctrl_host.sv
// Self-checking bench for sim_ctrl_host: responder model plus a scoreboard of expected
// bus writes, table-driven single-character vectors and hand-written corner sequences.
module tb_sim_ctrl_host;

  localparam logic [31:0] Base  = 32'h0002_0000;
  localparam int unsigned Depth = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        char_valid_i = 1'b0;
  logic [7:0]  char_i = 8'h0;
  logic        char_ready_o;
  logic        halt_i = 1'b0;
  logic        req_o;
  logic        we_o;
  logic [3:0]  be_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic        rvalid_i = 1'b0;
  logic [3:0]  count_o;
  logic        busy_o;
  logic        halted_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  sim_ctrl_host #(
    .BaseAddr  (Base),
    .FifoDepth (Depth),
    .RspTimeout(16)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .char_valid_i(char_valid_i),
    .char_i      (char_i),
    .char_ready_o(char_ready_o),
    .halt_i      (halt_i),
    .req_o       (req_o),
    .we_o        (we_o),
    .be_o        (be_o),
    .addr_o      (addr_o),
    .wdata_o     (wdata_o),
    .rvalid_i    (rvalid_i),
    .count_o     (count_o),
    .busy_o      (busy_o),
    .halted_o    (halted_o),
    .err_o       (err_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic [7:0]  ch;
    logic [31:0] exp_wdata;
  } vec_t;

  txn_t  exp_q[$];
  int    req_cyc[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  int    n_req = 0;
  string log_s = "";
  bit    ack_en = 1'b1;
  bit    drop_next = 1'b0;
  bit    pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Responder answers one cycle after req (or later while stalled); monitor scores each write.
  initial begin : monitor
    txn_t t;
    forever begin
      @(posedge clk_i);
      #2;
      cyc++;
      if (!rst_ni) begin
        pend     = 1'b0;
        rvalid_i = 1'b0;
      end else begin
        rvalid_i = ack_en && pend;
        if (rvalid_i) pend = 1'b0;
        if (req_o) begin
          n_req++;
          req_cyc.push_back(cyc);
          if (drop_next) drop_next = 1'b0;
          else pend = 1'b1;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_req: got addr %h data %h, expected no request",
                     addr_o, wdata_o);
          end else begin
            t = exp_q.pop_front();
            chk("bus_addr", addr_o, t.addr);
            chk("bus_wdata", wdata_o, t.data);
            chk("bus_be", {28'h0, be_o}, 32'h1);
            chk("bus_we", {31'h0, we_o}, 32'h1);
            if (addr_o == Base) log_s = $sformatf("%s%c", log_s, wdata_o[7:0]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  task automatic push_one(input logic [7:0] c);
    int k;
    k = 0;
    while (!char_ready_o && k < 50) begin
      step();
      k++;
    end
    chk("push_ready", {31'h0, char_ready_o}, 32'h1);
    if (char_ready_o) begin
      char_valid_i = 1'b1;
      char_i       = c;
      exp_q.push_back('{Base, {24'h0, c}});
      step();
      char_valid_i = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int k;
    k = 0;
    while ((busy_o || exp_q.size() != 0) && k < maxc) begin
      step();
      k++;
    end
    chk(name, {31'h0, busy_o || (exp_q.size() != 0)}, 32'h0);
  endtask

  initial begin : main
    vec_t vecs[5];
    int   d;
    int   n0;
    int   k;

    vecs[0] = '{8'h48, 32'h0000_0048};
    vecs[1] = '{8'h69, 32'h0000_0069};
    vecs[2] = '{8'h00, 32'h0000_0000};
    vecs[3] = '{8'hFF, 32'h0000_00FF};
    vecs[4] = '{8'hA5, 32'h0000_00A5};

    // Reset values
    step_n(2);
    chk("rst_req", {31'h0, req_o}, 32'h0);
    chk("rst_we", {31'h0, we_o}, 32'h0);
    chk("rst_be", {28'h0, be_o}, 32'h0);
    chk("rst_addr", addr_o, 32'h0);
    chk("rst_wdata", wdata_o, 32'h0);
    chk("rst_count", {28'h0, count_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_halted", {31'h0, halted_o}, 32'h0);
    chk("rst_err", {31'h0, err_o}, 32'h0);
    chk("rst_ready", {31'h0, char_ready_o}, 32'h1);
    rst_ni = 1'b1;
    step_n(2);

    // Single characters from idle: req one edge after the push edge, one-cycle pulse
    for (int i = 0; i < 5; i++) begin
      push_one(vecs[i].ch);
      chk("vec_req_early", {31'h0, req_o}, 32'h0);
      chk("vec_count1", {28'h0, count_o}, 32'h1);
      step();
      chk("vec_req", {31'h0, req_o}, 32'h1);
      chk("vec_wdata", wdata_o, vecs[i].exp_wdata);
      chk("vec_addr", addr_o, Base);
      chk("vec_count0", {28'h0, count_o}, 32'h0);
      step();
      chk("vec_req_pulse", {31'h0, req_o}, 32'h0);
      chk("vec_wdata_hold", wdata_o, vecs[i].exp_wdata);
      wait_idle("vec_idle", 40);
    end

    // "Hi" back-to-back: writes 3 cycles apart
    req_cyc.delete();
    log_s = "";
    chk("hi_ready", {31'h0, char_ready_o}, 32'h1);
    char_valid_i = 1'b1;
    char_i       = 8'h48;
    exp_q.push_back('{Base, 32'h48});
    step();
    chk("hi_ready2", {31'h0, char_ready_o}, 32'h1);
    char_i = 8'h69;
    exp_q.push_back('{Base, 32'h69});
    step();
    char_valid_i = 1'b0;
    wait_idle("hi_idle", 40);
    chk("hi_nreq", 32'(req_cyc.size()), 32'd2);
    d = (req_cyc.size() >= 2) ? (req_cyc[1] - req_cyc[0]) : -1;
    chk("hi_gap", 32'(d), 32'd3);
    n_checks++;
    if (log_s != "Hi") begin
      n_errors++;
      $display("FAIL hi_log: got \"%s\", expected \"Hi\"", log_s);
    end

    // Stalled responder fills the FIFO; release drains in order
    ack_en = 1'b0;
    n0     = n_req;
    char_valid_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      char_i = 8'h30 + 8'(i);
      exp_q.push_back('{Base, 32'h30 + 32'(i)});
      step();
    end
    chk("full_count", {28'h0, count_o}, 32'd8);
    chk("full_ready", {31'h0, char_ready_o}, 32'h0);
    char_i = 8'hEE;
    step();
    char_valid_i = 1'b0;
    chk("full_no_push", {28'h0, count_o}, 32'd8);
    ack_en = 1'b1;
    wait_idle("full_drain", 200);
    chk("full_count0", {28'h0, count_o}, 32'h0);
    chk("full_nreq", 32'(n_req - n0), 32'd9);
    chk("full_err", {31'h0, err_o}, 32'h0);

    // Response timeout: err after 16 wait cycles, no retry, next byte normal
    drop_next = 1'b1;
    push_one(8'h78);
    step();
    chk("to_req", {31'h0, req_o}, 32'h1);
    step_n(14);
    chk("to_err_early", {31'h0, err_o}, 32'h0);
    step_n(3);
    chk("to_err", {31'h0, err_o}, 32'h1);
    chk("to_idle", {31'h0, busy_o}, 32'h0);
    push_one(8'h79);
    wait_idle("to_next", 40);
    chk("to_err_sticky", {31'h0, err_o}, 32'h1);

    // Asynchronous reset during WAIT discards everything
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) push_one(8'h61 + 8'(i));
    chk("rw_count", {28'h0, count_o}, 32'd3);
    step_n(2);
    chk("rw_busy", {31'h0, busy_o}, 32'h1);
    rst_ni = 1'b0;
    #1;
    chk("rw_req", {31'h0, req_o}, 32'h0);
    chk("rw_count0", {28'h0, count_o}, 32'h0);
    chk("rw_err", {31'h0, err_o}, 32'h0);
    chk("rw_busy0", {31'h0, busy_o}, 32'h0);
    chk("rw_ready", {31'h0, char_ready_o}, 32'h1);
    exp_q.delete();
    step();
    rst_ni = 1'b1;
    ack_en = 1'b1;
    n0     = n_req;
    step_n(10);
    chk("rw_no_req", 32'(n_req), 32'(n0));
    chk("rw_still_empty", {28'h0, count_o}, 32'h0);

    // Halt with bytes queued and a byte pushed in the same cycle
    ack_en = 1'b0;
    push_one(8'h61);
    push_one(8'h62);
    char_valid_i = 1'b1;
    char_i       = 8'h41;
    halt_i       = 1'b1;
    exp_q.push_back('{Base, 32'h41});
    exp_q.push_back('{Base + 32'h8, 32'h1});
    step();
    char_valid_i = 1'b0;
    halt_i       = 1'b0;
    chk("hl_count", {28'h0, count_o}, 32'd2);
    chk("hl_ready", {31'h0, char_ready_o}, 32'h0);
    step_n(2);
    halt_i = 1'b1;
    step();
    halt_i = 1'b0;
    ack_en = 1'b1;
    k = 0;
    while (!halted_o && k < 100) begin
      step();
      k++;
    end
    chk("hl_halted", {31'h0, halted_o}, 32'h1);
    chk("hl_all_done", 32'(exp_q.size()), 32'h0);
    chk("hl_ready_after", {31'h0, char_ready_o}, 32'h0);
    chk("hl_err", {31'h0, err_o}, 32'h0);
    chk("hl_addr_hold", addr_o, Base + 32'h8);

    // HALTED ignores further halts and pushes
    n0           = n_req;
    halt_i       = 1'b1;
    char_valid_i = 1'b1;
    char_i       = 8'h5A;
    step();
    halt_i = 1'b0;
    step_n(20);
    char_valid_i = 1'b0;
    chk("hd_no_req", 32'(n_req), 32'(n0));
    chk("hd_count", {28'h0, count_o}, 32'h0);
    chk("hd_halted", {31'h0, halted_o}, 32'h1);
    chk("hd_wdata_hold", wdata_o, 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
